// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and the double-dabble step used by the
// binary-to-BCD conversion scheduler and its shift core.
package bcd_pkg;

  localparam int BIN_W = 14;
  localparam int BCD_W = 16;
  localparam int SCR_W = BCD_W + BIN_W;
  localparam int ITER = 14;
  localparam logic [BIN_W-1:0] MAX_DEC = 14'd9999;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    OUT
  } state_t;

  // One shift/add-3 iteration: correct every BCD nibble >= 5, then shift left.
  function automatic logic [SCR_W-1:0] bcd_iter(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] t;
    t = s;
    for (int d = 0; d < BCD_W / 4; d++) begin
      if (t[BIN_W + 4*d +: 4] >= 4'd5) begin
        t[BIN_W + 4*d +: 4] = t[BIN_W + 4*d +: 4] + 4'd3;
      end
    end
    return {t[SCR_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/bcd_shift_core.sv
// Iterative 14-bit binary-to-BCD engine. The first iteration is applied while
// loading; done is raised in the cycle that produces the 14th iteration.
module bcd_shift_core
  import bcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        done
);

  logic [SCR_W-1:0] scr_reg;
  logic [SCR_W-1:0] scr_step;
  logic [3:0]       cnt_reg;
  logic             run_reg;

  assign scr_step = bcd_iter(scr_reg);
  assign done     = run_reg && (cnt_reg == 4'(ITER - 1));
  // The final iteration is combinational so the result lines up with done.
  assign bcd      = scr_step[SCR_W-1:BIN_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scr_reg <= '0;
      cnt_reg <= '0;
      run_reg <= 1'b0;
    end else if (start) begin
      scr_reg <= bcd_iter({16'h0000, bin});
      cnt_reg <= 4'd1;
      run_reg <= 1'b1;
    end else if (run_reg) begin
      if (done) begin
        run_reg <= 1'b0;
      end else begin
        scr_reg <= scr_step;
        cnt_reg <= cnt_reg + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one binary-to-BCD engine among NCH requesters,
// with valid/ready handshakes on the request and result sides.
module bcd_conv_scheduler #(
  parameter int NCH = 4,
  parameter int BIN_W = 14,
  localparam int CH_W = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       req_valid,
  input  logic [NCH*BIN_W-1:0] req_data,
  output logic [NCH-1:0]       req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [15:0]          res_bcd,
  output logic [CH_W-1:0]      res_ch,
  output logic                 res_ovf,
  output logic                 busy
);

  import bcd_pkg::*;

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   rr_ptr_reg;
  logic [CH_W-1:0]   sel_idx;
  logic              sel_found;
  logic [BIN_W-1:0]  sel_data;
  logic [BIN_W-1:0]  op_reg;
  logic              first_reg;
  logic              transfer;
  logic              core_start;
  logic              core_done;
  logic [15:0]       core_bcd;

  // Scan from rr_ptr downward in priority; the last hit is the closest to rr_ptr.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (req_valid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = CH_W'(idx);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_grant
      assign req_ready[gi] = rst_n && (state_reg == IDLE) && sel_found
                             && (sel_idx == CH_W'(gi));
    end
  endgenerate

  assign transfer   = |req_ready;
  assign sel_data   = req_data[sel_idx*BIN_W +: BIN_W];
  assign core_start = (state_reg == CONV) && first_reg;
  assign busy       = (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (transfer) state_next = CONV;
      CONV:    if (core_done) state_next = OUT;
      OUT:     if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      op_reg     <= '0;
      first_reg  <= 1'b0;
      res_valid  <= 1'b0;
      res_bcd    <= 16'h0000;
      res_ch     <= '0;
      res_ovf    <= 1'b0;
    end else begin
      state_reg <= state_next;
      first_reg <= transfer;
      if (transfer) begin
        op_reg     <= (sel_data > MAX_DEC) ? MAX_DEC : sel_data;
        res_ovf    <= (sel_data > MAX_DEC);
        res_ch     <= sel_idx;
        rr_ptr_reg <= (sel_idx == CH_W'(NCH - 1)) ? '0 : sel_idx + 1'b1;
      end
      if (state_reg == CONV && core_done) begin
        res_bcd   <= core_bcd;
        res_valid <= 1'b1;
      end
      if (state_reg == OUT && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  bcd_shift_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (core_start),
    .bin   (op_reg),
    .bcd   (core_bcd),
    .done  (core_done)
  );

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed and randomized bench for bcd_conv_scheduler against a decimal-arithmetic
// reference model with a round-robin pointer kept in plain integer form.
module tb_bcd_conv_scheduler;

  localparam int NCH = 4;
  localparam int BW = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    req_valid = '0;
  logic [NCH*BW-1:0] req_data = '0;
  logic [NCH-1:0]    req_ready;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [15:0]       res_bcd;
  logic [1:0]        res_ch;
  logic              res_ovf;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int rr_model = 0;

  bcd_conv_scheduler #(.NCH(NCH), .BIN_W(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_bcd   (res_bcd),
    .res_ch    (res_ch),
    .res_ovf   (res_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  // Waits for a grant, predicts it, then follows the conversion to its result.
  // Returns in the cycle where res_valid is first seen high.
  task automatic transact(input bit drop, input bit scramble, input bit chk_tput);
    int n;
    int ech;
    int val;
    int c;
    #1;
    n = 0;
    while (req_ready == '0 && n < 40) begin
      tick();
      #1;
      n++;
    end
    ech = -1;
    for (int k = 0; k < NCH; k++) begin
      c = (rr_model + k) % NCH;
      if (ech < 0 && req_valid[c]) ech = c;
    end
    if (ech < 0) begin
      checks++;
      errors++;
      $error("FAIL no_requester observed=%0h expected=nonzero", req_valid);
      return;
    end
    check("grant_onehot", 32'(req_ready), 32'(1) << ech);
    if (chk_tput) check("throughput_wait", 32'(n), 32'd0);
    val = int'(req_data[ech*BW +: BW]);
    rr_model = (ech + 1) % NCH;
    tick();
    if (drop) req_valid[ech] = 1'b0;
    if (scramble) begin
      for (int k = 0; k < NCH; k++) req_data[k*BW +: BW] = BW'($urandom_range(0, 16383));
    end
    #1;
    check("ready_in_conv", 32'(req_ready), 32'd0);
    n = 1;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'd15);
    check("res_bcd", 32'(res_bcd), 32'(ref_bcd(val)));
    check("res_ch", 32'(res_ch), 32'(ech));
    check("res_ovf", 32'(res_ovf), 32'(val > 9999));
    $display("txn ch=%0d op=%0d bcd=%h ovf=%0d lat=%0d", ech, val, res_bcd, res_ovf, n);
  endtask

  initial begin
    logic [15:0] snap_bcd;
    logic [1:0]  snap_ch;
    logic        snap_ovf;
    bit          stable;

    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_bcd", 32'(res_bcd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    tick();

    // Directed operands including the clamp boundaries.
    req_data[0*BW +: BW] = 14'd1234; req_valid = 4'b0001;
    transact(1, 1, 0); tick();
    req_data[2*BW +: BW] = 14'd16383; req_valid = 4'b0100;
    transact(1, 1, 0); tick();
    req_data[1*BW +: BW] = 14'd0; req_valid = 4'b0010;
    transact(1, 1, 0); tick();
    req_data[3*BW +: BW] = 14'd9999; req_valid = 4'b1000;
    transact(1, 1, 0); tick();
    req_data[0*BW +: BW] = 14'd10000; req_valid = 4'b0001;
    transact(1, 1, 0); tick();

    // Random masks and operands; ungranted channels keep waiting.
    for (int t = 0; t < 10; t++) begin
      req_valid = req_valid | NCH'($urandom_range(1, 15));
      for (int k = 0; k < NCH; k++) req_data[k*BW +: BW] = BW'($urandom_range(0, 16383));
      transact(1, 1, 0); tick();
    end
    req_valid = '0;
    tick();

    // All channels held valid: strict rotation at full throughput.
    req_data = {14'd44, 14'd33, 14'd22, 14'd11};
    req_valid = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      transact(0, 0, t > 0); tick();
    end

    // Backpressure: result held, no grant while others wait.
    res_ready = 1'b0;
    transact(0, 0, 1);
    snap_bcd = res_bcd; snap_ch = res_ch; snap_ovf = res_ovf;
    stable = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (!(res_valid === 1'b1 && res_bcd === snap_bcd && res_ch === snap_ch &&
            res_ovf === snap_ovf && req_ready === '0 && busy === 1'b1)) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    res_ready = 1'b1;
    tick();
    check("bp_retired", 32'(res_valid), 32'd0);
    transact(0, 0, 1); tick();
    req_valid = '0;
    tick();

    // Reset in the middle of a conversion.
    req_data[2*BW +: BW] = 14'd4321; req_valid = 4'b0100;
    #1;
    check("rst_test_grant", 32'(req_ready), 32'h4);
    repeat (7) begin
      tick();
      req_valid = '0;
    end
    rst_n = 1'b0;
    tick();
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_res_bcd", 32'(res_bcd), 32'd0);
    check("midrst_res_ch", 32'(res_ch), 32'd0);
    check("midrst_res_ovf", 32'(res_ovf), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    rr_model = 0;
    req_data[1*BW +: BW] = 14'd5678;
    req_data[3*BW +: BW] = 14'd8765;
    req_valid = 4'b1010;
    transact(1, 0, 0); tick();
    transact(1, 1, 0); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_conv_scheduler.md
# bcd_conv_scheduler

Shares one iterative 14-bit binary-to-BCD conversion engine among NCH independent requesters (ADC channels, counters, the display mux) using round-robin arbitration and valid/ready handshakes on both sides. It sits between the binary producers and the seven-segment display path. It accepts one binary word at a time, runs the 14-iteration shift/add-3 sequence, and returns a 4-digit packed BCD result tagged with the originating channel.

## Interface
- NCH, 4: number of requester channels, 2..8.
- BIN_W, 14: binary input width; fixed by the engine.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NCH  per-channel request valid.
- req_data  in  NCH*BIN_W  per-channel binary operand; channel i occupies bits [i*BIN_W +: BIN_W].
- req_ready  out  NCH  one-hot-or-zero grant/accept strobe.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_bcd  out  16  packed BCD, thousands digit in [15:12].
- res_ch  out  $clog2(NCH)  channel index of the result.
- res_ovf  out  1  operand exceeded 9999 and was clamped.
- busy  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, CONV, OUT. Reset enters IDLE.
- IDLE:
  - Arbiter scans channels starting at rr_ptr, wrapping modulo NCH, and selects the first i with req_valid[i]=1.
  - req_ready[i]=1 combinationally for that i only. The transfer occurs in that cycle.
  - On transfer:
    - Latch the operand, clamped to 9999 when greater than 9999.
    - Latch res_ovf and the channel index.
    - Set rr_ptr=(i+1) mod NCH.
    - Go to CONV.
  - With no valid request, stay in IDLE and drive req_ready=0.
- CONV:
  - Assert start to the core on the first CONV cycle.
  - The core runs exactly 14 iterations. Each iteration first adds 3 to every BCD nibble that is ≥5, then shifts left by 1.
  - On core done, register the result into res_bcd, set res_valid=1, and go to OUT.
  - req_ready=0 throughout CONV.
- OUT:
  - Hold res_valid, res_bcd, res_ch, and res_ovf stable until res_ready=1.
  - On res_valid&res_ready, clear res_valid and go to IDLE.
  - req_ready=0 in OUT. There is no acceptance in the same cycle as result retirement.
- Arithmetic:
  - Scratch register is 30 bits: 16 BCD plus 14 binary.
  - The clamp guarantees 4 valid digits, so no digit ever exceeds 9 and no carry is lost.
- Boundary conditions:
  - Simultaneous requests: strictly round-robin from rr_ptr. A channel that holds req_valid is served within NCH grants.
  - rr_ptr wrap: NCH-1 is followed by 0.
  - req_valid dropped by a requester before its grant: no transfer occurs.
  - req_data is sampled only in the grant cycle. Later changes have no effect.
  - Reset mid-operation:
    - Abort the conversion and discard the partial result.
    - rr_ptr=0.
    - All outputs return to their reset values in the cycle after rst_n is sampled low.
- Reset values: req_ready=0, res_valid=0, res_bcd=16'h0000, res_ch=0, res_ovf=0, busy=0, rr_ptr=0.

## Timing
- The grant is in cycle T. CONV occupies T+1..T+14. res_valid rises at T+15, so latency is 15 cycles from accept to result.
- With res_ready held high, the result retires at T+15. The next grant is possible at T+16, giving 16-cycle throughput per conversion.
- Backpressure extends OUT indefinitely with no data change.
- req_ready is combinational from state, rr_ptr and req_valid. All other outputs are registered.

## Structure
- Package bcd_pkg holds:
  - BIN_W=14, BCD_W=16, MAX_DEC=14'd9999, ITER=14.
  - State enum typedef {IDLE, CONV, OUT}.
- Sub-module bcd_shift_core is the iterative engine.
  - Ports: clk, rst_n, start, bin[13:0], bcd[15:0], done.
  - It asserts done for 1 cycle after the 14th iteration. bcd is valid in the done cycle.
- The scheduler contains only the arbiter, the FSM and the output registers.

## Test plan
- ch0 requests 1234, res_ready=1 → res_bcd=16'h1234, res_ch=0, res_ovf=0, res_valid at grant+15.
- ch2 requests 16383 → res_bcd=16'h9999, res_ovf=1; separately, 0 → 16'h0000 and 9999 → 16'h9999 with res_ovf=0.
- All 4 channels valid continuously with distinct values 11, 22, 33, 44 → results in channel order 0,1,2,3,0,… and req_ready one-hot each grant.
- Result pending with res_ready=0 for 40 cycles → outputs stable, req_ready=0, no new grant; res_ready=1 → retire, then grant of the next channel.
- rst_n low at grant+7 of a conversion → the next cycle has all outputs at reset values; a subsequent ch1 request gets granted first from rr_ptr=0 and its result is correct.
- req_data changed during CONV → result reflects the operand sampled at the grant.
